stream_concat: RTL and testbench

Parametrised, handshaked successor to the fixed-width concat primitives in the LVDS datapath. It joins `NUM_LANES` independent valid/ready lanes of `LANE_W` bits each into one wide word, with lane 0 in the LSBs. Each lane has its own holding register, so lanes may arrive in any order and on different cycles. Per-lane masking lets unused lanes be zero-filled instead of stalling the join. It sits between the per-channel deserialiser/decimator outputs and the wide sample bus feeding the demodulator.

---
 rtl/stream_concat_if.sv | 59 +++++
 rtl/stream_concat.sv | 193 +++++++++++++++++++
 tb/tb_stream_concat.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/stream_concat_if.sv
// ---------------------------------------------------------------------------
// stream_concat_if
//
// Bundles the handshake and data signals of the stream_concat lane joiner.
//
//   in_data    NUM_LANES*LANE_W  lane i in bits [i*LANE_W +: LANE_W]
//   in_valid   NUM_LANES         per-lane valid
//   in_ready   NUM_LANES         per-lane ready
//   lane_mask  NUM_LANES         1 = lane zero-filled, never waited on
//   out_data   NUM_LANES*LANE_W  joined word, lane 0 in the LSBs
//   out_valid  1                 joined word valid
//   out_ready  1                 downstream ready
//   out_count  16                words emitted, wraps 0xFFFF -> 0
//
// Modports:
//   master  the surroundings (lane sources plus the wide-bus sink)
//   slave   the stream_concat block itself
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface stream_concat_if #(
    parameter int NUM_LANES = 2,
    parameter int LANE_W    = 8
);
    localparam int OUT_W = NUM_LANES * LANE_W;

    logic [OUT_W-1:0]     in_data;
    logic [NUM_LANES-1:0] in_valid;
    logic [NUM_LANES-1:0] in_ready;
    logic [NUM_LANES-1:0] lane_mask;
    logic [OUT_W-1:0]     out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [15:0]          out_count;

    // Upstream lanes and the downstream consumer, seen from outside the block
    modport master (
        output in_data,
        output in_valid,
        output lane_mask,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_valid,
        input  out_count
    );

    // The joiner itself
    modport slave (
        input  in_data,
        input  in_valid,
        input  lane_mask,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_valid,
        output out_count
    );
endinterface

// File: rtl/stream_concat.sv
// ---------------------------------------------------------------------------
// stream_concat
//
// Joins NUM_LANES independent valid/ready lanes of LANE_W bits into a single
// wide word (lane 0 in the LSBs). Every lane owns a holding register, so
// lanes may arrive in any order and on different cycles. A word is emitted
// once every unmasked lane holds data; masked lanes are zero-filled and
// never waited on. An all-masked lane set never emits anything.
//
// Ports:
//   clk    sole clock
//   rst_n  asynchronous active-low reset
//   bus    stream_concat_if.slave: in_data/in_valid/in_ready/lane_mask on
//          the lane side, out_data/out_valid/out_ready/out_count on the
//          wide side
//
// Parameters:
//   NUM_LANES  number of lanes, 2..8
//   LANE_W     bits per lane, 1..32
//
// Build option:
//   STREAM_CONCAT_SKID_EN  when defined the output stage is a 2-entry skid
//                          buffer and out_ready no longer reaches in_ready
//                          combinationally. Undefined: one output register,
//                          with a combinational out_ready -> in_ready path.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module stream_concat #(
    parameter int NUM_LANES = 2,
    parameter int LANE_W    = 8
) (
    input logic           clk,
    input logic           rst_n,
    stream_concat_if.slave bus
);
    localparam int OUT_W = NUM_LANES * LANE_W;

    logic [LANE_W-1:0]    hold_data [NUM_LANES];
    logic [NUM_LANES-1:0] hold_full;
    logic [NUM_LANES-1:0] in_ready_c;
    logic [NUM_LANES-1:0] accept;
    logic                 all_present;
    logic                 out_space;
    logic                 fire;
    logic [OUT_W-1:0]     join_word;
    logic [15:0]          out_count_q;

    // A word is ready to leave when every lane is either held or masked, but
    // a fully masked set is excluded so it cannot spin out zero words. The
    // word only leaves when the output stage has room for it.
    always_comb begin
        all_present = (&(hold_full | bus.lane_mask)) & ~(&bus.lane_mask);
        fire        = all_present & out_space;
    end

    // A lane is ready when its holding register is empty or is being drained
    // on this very edge, which lets a full lane refill back-to-back. Masked
    // lanes always accept so upstream never stalls on them; their data is
    // dropped.
    always_comb begin
        in_ready_c = '0;
        accept     = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            in_ready_c[i] = bus.lane_mask[i] | ~hold_full[i] | fire;
            accept[i]     = bus.in_valid[i] & in_ready_c[i] & ~bus.lane_mask[i];
        end
    end

    assign bus.in_ready = in_ready_c;

    // Assemble the outgoing word from the holding registers, forcing masked
    // lanes to zero rather than leaking whatever they last held.
    always_comb begin
        join_word = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (!bus.lane_mask[i]) begin
                join_word[i*LANE_W +: LANE_W] = hold_data[i];
            end
        end
    end

    // Per-lane holding registers. Masking wins over everything: it empties
    // the lane (discarding held data) and keeps it empty, so unmasking
    // later starts from a clean lane. A new beat taking the lane on the same
    // edge as a drain leaves it full with the new data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_full <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                hold_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (bus.lane_mask[i]) begin
                    hold_full[i] <= 1'b0;
                end else if (accept[i]) begin
                    hold_full[i] <= 1'b1;
                    hold_data[i] <= bus.in_data[i*LANE_W +: LANE_W];
                end else if (fire) begin
                    hold_full[i] <= 1'b0;
                end
            end
        end
    end

    // Words-emitted counter; rolls over from 0xFFFF to 0 without any flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_count_q <= '0;
        end else if (fire) begin
            out_count_q <= out_count_q + 16'd1;
        end
    end

    assign bus.out_count = out_count_q;

`ifdef STREAM_CONCAT_SKID_EN
    logic [OUT_W-1:0] skid_mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       skid_cnt;
    logic             push;
    logic             pop;

    // Room is judged from the registered occupancy only, which is what
    // breaks the out_ready -> in_ready path. With one word in flight and the
    // consumer draining every cycle the count stays at 1, so throughput is
    // still one word per clock.
    always_comb begin
        out_space = (skid_cnt != 2'd2);
        push      = fire;
        pop       = (skid_cnt != 2'd0) & bus.out_ready;
    end

    // Two-entry circular buffer. The head entry is never the write target
    // while it is valid, so out_data stays stable until it is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_mem[0] <= '0;
            skid_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            skid_cnt    <= 2'd0;
        end else begin
            if (push) begin
                skid_mem[wr_ptr] <= join_word;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   skid_cnt <= skid_cnt + 2'd1;
                2'b01:   skid_cnt <= skid_cnt - 2'd1;
                default: skid_cnt <= skid_cnt;
            endcase
        end
    end

    assign bus.out_data  = skid_mem[rd_ptr];
    assign bus.out_valid = (skid_cnt != 2'd0);
`else
    logic [OUT_W-1:0] out_data_q;
    logic             out_valid_q;

    // The single output register has room when empty or when its word is
    // being taken this cycle; this is the combinational path from out_ready
    // back to the lanes' in_ready.
    always_comb begin
        out_space = ~out_valid_q | bus.out_ready;
    end

    // Output register. A new word overwrites a word that is drained on the
    // same edge, keeping out_valid high; otherwise valid only falls after
    // the consumer has taken the word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else if (fire) begin
            out_data_q  <= join_word;
            out_valid_q <= 1'b1;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
`endif

endmodule

// File: tb/tb_stream_concat.sv
// ---------------------------------------------------------------------------
// tb_stream_concat
//
// Directed bench for stream_concat with NUM_LANES=2, LANE_W=8: a table of
// per-cycle vectors for the single-word, masking and all-masked cases, then
// hand-written sequences for streaming, backpressure, counter wrap and
// reset while a word is pending. Expectations hold for both output-stage
// builds.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_stream_concat;
    localparam int NUM_LANES = 2;
    localparam int LANE_W    = 8;
    localparam int NV        = 19;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    stream_concat_if #(.NUM_LANES(NUM_LANES), .LANE_W(LANE_W)) bus ();

    stream_concat #(.NUM_LANES(NUM_LANES), .LANE_W(LANE_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]  valid;
        logic [15:0] data;
        logic [1:0]  mask;
        logic        ordy;
        logic        exp_ov;
        logic [15:0] exp_od;
        logic [1:0]  exp_ir;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t        vecs [NV];
    int          vec_count = 0;
    int          miss_count = 0;
    logic [15:0] exp_q [$];
    logic [7:0]  next_val = 8'h00;
    logic        stall_seen = 1'b0;
    logic [15:0] stall_word = 16'h0000;
    int          words_seen = 0;
    int          total_accepted = 0;

    function automatic vec_t mk(input logic [1:0] v, input logic [15:0] d,
                                input logic [1:0] m, input logic r,
                                input logic eov, input logic [15:0] eod,
                                input logic [1:0] eir, input logic [15:0] ecnt);
        vec_t t;
        t.valid   = v;
        t.data    = d;
        t.mask    = m;
        t.ordy    = r;
        t.exp_ov  = eov;
        t.exp_od  = eod;
        t.exp_ir  = eir;
        t.exp_cnt = ecnt;
        return t;
    endfunction

    // Drive one cycle's worth of inputs
    task automatic applyStimulus(input logic [1:0] valid, input logic [15:0] data,
                                 input logic [1:0] mask, input logic ordy);
        bus.in_valid  = valid;
        bus.in_data   = data;
        bus.lane_mask = mask;
        bus.out_ready = ordy;
    endtask

    // One comparison: counts it and reports a miscompare
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    // One streaming cycle with both lanes carrying an incrementing pattern.
    // Accepted words go into an ordered queue; every word the consumer takes
    // must be the oldest outstanding one, and a stalled word must not change.
    task automatic streamCycle(input logic drive, input logic ordy, input logic chk_ready);
        logic [7:0]  hi;
        logic [15:0] w;
        hi = next_val + 8'h80;
        w  = {hi, next_val};
        applyStimulus(drive ? 2'b11 : 2'b00, w, 2'b00, ordy);
        #1;
        if (chk_ready) checkOutput("stream in_ready", 32'(bus.in_ready), 32'h3);
        if (stall_seen) begin
            checkOutput("stall out_valid held", 32'(bus.out_valid), 32'h1);
            checkOutput("stall out_data stable", 32'(bus.out_data), 32'(stall_word));
        end
        if (bus.out_valid && ordy) begin
            if (exp_q.size() == 0) begin
                vec_count++;
                miss_count++;
                $display("[TB] FAIL spurious word: got 0x%0h, want no word", bus.out_data);
            end else begin
                checkOutput("stream word", 32'(bus.out_data), 32'(exp_q.pop_front()));
                words_seen++;
            end
        end
        stall_seen = bus.out_valid && !ordy;
        stall_word = bus.out_data;
        if (drive && bus.in_ready == 2'b11) begin
            exp_q.push_back(w);
            next_val++;
            total_accepted++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        //              valid  data      mask   rdy  ov    od        ir     cnt
        vecs[0]  = mk(2'b00, 16'h0000, 2'b00, 1'b1, 1'b0, 16'h0000, 2'b11, 16'd0);
        vecs[1]  = mk(2'b01, 16'h0012, 2'b00, 1'b1, 1'b0, 16'h0000, 2'b11, 16'd0);
        vecs[2]  = mk(2'b00, 16'h0000, 2'b00, 1'b1, 1'b0, 16'h0000, 2'b10, 16'd0);
        vecs[3]  = mk(2'b10, 16'h3400, 2'b00, 1'b1, 1'b0, 16'h0000, 2'b10, 16'd0);
        vecs[4]  = mk(2'b00, 16'h0000, 2'b00, 1'b1, 1'b0, 16'h0000, 2'b11, 16'd0);
        vecs[5]  = mk(2'b00, 16'h0000, 2'b00, 1'b1, 1'b1, 16'h3412, 2'b11, 16'd1);
        vecs[6]  = mk(2'b01, 16'h00AB, 2'b10, 1'b1, 1'b0, 16'h0000, 2'b11, 16'd1);
        vecs[7]  = mk(2'b10, 16'h5500, 2'b10, 1'b1, 1'b0, 16'h0000, 2'b11, 16'd1);
        vecs[8]  = mk(2'b00, 16'h0000, 2'b10, 1'b1, 1'b1, 16'h00AB, 2'b11, 16'd2);
        vecs[9]  = mk(2'b10, 16'h7700, 2'b00, 1'b1, 1'b0, 16'h0000, 2'b11, 16'd2);
        vecs[10] = mk(2'b00, 16'h0000, 2'b10, 1'b1, 1'b0, 16'h0000, 2'b11, 16'd2);
        vecs[11] = mk(2'b00, 16'h0000, 2'b00, 1'b1, 1'b0, 16'h0000, 2'b11, 16'd2);
        vecs[12] = mk(2'b01, 16'h0099, 2'b10, 1'b1, 1'b0, 16'h0000, 2'b11, 16'd2);
        vecs[13] = mk(2'b00, 16'h0000, 2'b10, 1'b1, 1'b0, 16'h0000, 2'b11, 16'd2);
        vecs[14] = mk(2'b00, 16'h0000, 2'b10, 1'b0, 1'b1, 16'h0099, 2'b11, 16'd3);
        vecs[15] = mk(2'b00, 16'h0000, 2'b10, 1'b1, 1'b1, 16'h0099, 2'b11, 16'd3);
        vecs[16] = mk(2'b11, 16'hEEFF, 2'b11, 1'b1, 1'b0, 16'h0000, 2'b11, 16'd3);
        vecs[17] = mk(2'b11, 16'hEEFF, 2'b11, 1'b1, 1'b0, 16'h0000, 2'b11, 16'd3);
        vecs[18] = mk(2'b00, 16'h0000, 2'b11, 1'b1, 1'b0, 16'h0000, 2'b11, 16'd3);

        // Reset state
        applyStimulus(2'b00, 16'h0000, 2'b00, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset out_valid", 32'(bus.out_valid), 32'h0);
        checkOutput("reset out_data", 32'(bus.out_data), 32'h0);
        checkOutput("reset out_count", 32'(bus.out_count), 32'h0);
        checkOutput("reset in_ready", 32'(bus.in_ready), 32'h3);
        rst_n = 1'b1;

        // Table-driven vectors
        for (int k = 0; k < NV; k++) begin
            applyStimulus(vecs[k].valid, vecs[k].data, vecs[k].mask, vecs[k].ordy);
            #1;
            checkOutput($sformatf("v%0d in_ready", k), 32'(bus.in_ready), 32'(vecs[k].exp_ir));
            checkOutput($sformatf("v%0d out_valid", k), 32'(bus.out_valid), 32'(vecs[k].exp_ov));
            if (vecs[k].exp_ov)
                checkOutput($sformatf("v%0d out_data", k), 32'(bus.out_data), 32'(vecs[k].exp_od));
            checkOutput($sformatf("v%0d out_count", k), 32'(bus.out_count), 32'(vecs[k].exp_cnt));
            @(posedge clk);
            #1;
        end

        // Continuous streaming: one word per clock after the first
        for (int c = 0; c < 20; c++) streamCycle(1'b1, 1'b1, 1'b1);
        checkOutput("stream throughput", 32'(words_seen), 32'd18);

        // Backpressure for 10 cycles while lanes keep presenting data
        for (int c = 0; c < 10; c++) streamCycle(1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("backpressure in_ready", 32'(bus.in_ready), 32'h0);
        for (int c = 0; c < 10; c++) streamCycle(1'b1, 1'b1, 1'b0);

        // Drain, bounded
        begin
            int budget;
            budget = 10;
            while (exp_q.size() > 0 && budget > 0) begin
                streamCycle(1'b0, 1'b1, 1'b0);
                budget--;
            end
        end
        checkOutput("drain outstanding", 32'(exp_q.size()), 32'd0);
        checkOutput("count after stream", 32'(bus.out_count), 32'(16'(3 + total_accepted)));

        // Counter wrap from a fresh reset
        rst_n = 1'b0;
        applyStimulus(2'b00, 16'h0000, 2'b00, 1'b1);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 65535; c++) begin
            applyStimulus(2'b11, 16'(c), 2'b00, 1'b1);
            @(posedge clk);
            #1;
        end
        applyStimulus(2'b00, 16'h0000, 2'b00, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("count at 0xFFFF", 32'(bus.out_count), 32'h0000FFFF);
        checkOutput("valid at 0xFFFF", 32'(bus.out_valid), 32'h1);
        applyStimulus(2'b11, 16'hBEEF, 2'b00, 1'b1);
        @(posedge clk);
        #1;
        applyStimulus(2'b00, 16'h0000, 2'b00, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("count wrapped", 32'(bus.out_count), 32'h0);
        checkOutput("wrap word valid", 32'(bus.out_valid), 32'h1);
        checkOutput("wrap word data", 32'(bus.out_data), 32'hBEEF);

        // Reset while a word is pending drops everything at once
        rst_n = 1'b0;
        #1;
        checkOutput("midrst out_valid", 32'(bus.out_valid), 32'h0);
        checkOutput("midrst out_data", 32'(bus.out_data), 32'h0);
        checkOutput("midrst out_count", 32'(bus.out_count), 32'h0);
        checkOutput("midrst in_ready", 32'(bus.in_ready), 32'h3);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post-reset out_valid", 32'(bus.out_valid), 32'h0);
        checkOutput("post-reset in_ready", 32'(bus.in_ready), 32'h3);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
